exp_series_seq: RTL and testbench



---
 rtl/exp_series_seq_pkg.sv | 30 +++
 rtl/exp_seq_fsm.sv | 80 ++++++++
 rtl/exp_series_seq.sv | 146 ++++++++++++++
 tb/tb_exp_series_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_series_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exp_series_seq_pkg
// Description : Shared state encoding and RF control constants for the
//               e^x Horner sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package exp_series_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_X     = 3'd1,
        RD_C     = 3'd2,
        MAC_GO   = 3'd3,
        MAC_WAIT = 3'd4,
        WR       = 3'd5,
        DONE     = 3'd6
    } state_t;

    // {WE, REB, REA}
    localparam logic [2:0] RF_NOP  = 3'b000;
    localparam logic [2:0] RF_RDA  = 3'b001;
    localparam logic [2:0] RF_RDAB = 3'b011;
    localparam logic [2:0] RF_WR   = 3'b100;

    localparam int COEF_BASE = 0;
    localparam int MAX_TERMS = 25;

endpackage : exp_series_seq_pkg
`default_nettype wire

// File: rtl/exp_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module      : exp_seq_fsm
// Description : State register plus next-state / control decode for the
//               e^x Horner sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_seq_fsm
    import exp_series_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       n_zero,
    input  logic       k_zero,
    input  logic       fma_done,
    output state_t     state,
    output logic [2:0] rf_enable,
    output logic       busy,
    output logic       done,
    output logic       fma_start
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        rf_enable = RF_NOP;
        busy      = 1'b1;
        done      = 1'b0;
        fma_start = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = RD_X;
            end
            RD_X: begin
                rf_enable = RF_RDAB;
                w_next    = n_zero ? WR : RD_C;
            end
            RD_C: begin
                rf_enable = RF_RDA;
                w_next    = MAC_GO;
            end
            MAC_GO: begin
                fma_start = 1'b1;
                w_next    = MAC_WAIT;
            end
            MAC_WAIT: begin
                if (fma_done) w_next = k_zero ? WR : RD_C;
            end
            WR: begin
                rf_enable = RF_WR;
                w_next    = DONE;
            end
            DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    assign state = r_state;

endmodule : exp_seq_fsm
`default_nettype wire

// File: rtl/exp_series_seq.sv
`default_nettype none
// ============================================================================
// Module      : exp_series_seq
// Description : Evaluates the Taylor series of e^x by Horner's method using
//               RF-resident 1/k! coefficients and an external FMA unit.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_series_seq
    import exp_series_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int NT_W      = 5,
    parameter int MAX_TERMS = exp_series_seq_pkg::MAX_TERMS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [NT_W-1:0]   n_terms,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [2:0]        rf_enable,
    output logic [ADDR_W-1:0] rf_raa,
    output logic [ADDR_W-1:0] rf_rab,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_outA,
    input  logic [DATA_W-1:0] rf_data_outB,
    output logic              fma_start,
    output logic [DATA_W-1:0] fma_a,
    output logic [DATA_W-1:0] fma_b,
    output logic [DATA_W-1:0] fma_c,
    input  logic              fma_done,
    input  logic [DATA_W-1:0] fma_result
);

    localparam logic [NT_W-1:0]   C_MAX_N     = NT_W'(MAX_TERMS);
    localparam logic [ADDR_W-1:0] C_COEF_BASE = ADDR_W'(COEF_BASE);

    state_t            w_state;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_coef;
    logic [NT_W-1:0]   r_k;
    logic [NT_W-1:0]   r_n;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_xaddr;
    logic              r_range_err;
    logic              w_clamp;
    logic [NT_W-1:0]   w_n;

    assign w_clamp = (n_terms > C_MAX_N);
    assign w_n     = w_clamp ? C_MAX_N : n_terms;

    exp_seq_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_zero    (r_n == '0),
        .k_zero    (r_k == '0),
        .fma_done  (fma_done),
        .state     (w_state),
        .rf_enable (rf_enable),
        .busy      (busy),
        .done      (done),
        .fma_start (fma_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_acc       <= '0;
            r_coef      <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_dst       <= '0;
            r_xaddr     <= '0;
            r_range_err <= 1'b0;
        end else begin
            case (w_state)
                IDLE: begin
                    if (start) begin
                        r_xaddr     <= x_addr;
                        r_dst       <= dst_addr;
                        r_n         <= w_n;
                        r_k         <= w_n;
                        r_range_err <= w_clamp;
                    end
                end
                RD_X: begin
                    // acc starts at the top coefficient c[N]
                    r_acc <= rf_data_outA;
                    r_x   <= rf_data_outB;
                    if (r_n != '0) r_k <= r_n - 1'b1;
                end
                RD_C: begin
                    r_coef <= rf_data_outA;
                end
                MAC_WAIT: begin
                    if (fma_done) begin
                        r_acc <= fma_result;
                        if (r_k != '0) r_k <= r_k - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address/data buses are forced to zero outside the states that use them
    always_comb begin
        rf_raa     = '0;
        rf_rab     = '0;
        rf_wa      = '0;
        rf_data_in = '0;
        fma_a      = '0;
        fma_b      = '0;
        fma_c      = '0;
        case (w_state)
            RD_X: begin
                rf_raa = C_COEF_BASE + ADDR_W'(r_n);
                rf_rab = r_xaddr;
            end
            RD_C: begin
                rf_raa = C_COEF_BASE + ADDR_W'(r_k);
            end
            MAC_GO, MAC_WAIT: begin
                fma_a = r_acc;
                fma_b = r_x;
                fma_c = r_coef;
            end
            WR: begin
                rf_wa      = r_dst;
                rf_data_in = r_acc;
            end
            default: ;
        endcase
    end

    assign range_err = r_range_err;

endmodule : exp_series_seq
`default_nettype wire

// File: tb/tb_exp_series_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_series_seq
// Description : Self-checking bench with RF model, behavioural FMA and a
//               Horner reference model for exp_series_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_series_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  x_addr;
    logic [5:0]  dst_addr;
    logic [4:0]  n_terms;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [2:0]  rf_enable;
    logic [5:0]  rf_raa;
    logic [5:0]  rf_rab;
    logic [5:0]  rf_wa;
    logic [31:0] rf_data_in;
    logic [31:0] rf_data_outA;
    logic [31:0] rf_data_outB;
    logic        fma_start;
    logic [31:0] fma_a;
    logic [31:0] fma_b;
    logic [31:0] fma_c;
    logic        fma_done;
    logic [31:0] fma_result;

    logic [31:0] mem [0:63];
    logic [31:0] coef [0:25];
    logic        fma_done_m;
    logic [31:0] fma_result_m;
    logic        spur;

    int ntests;
    int nfail;
    int lat;
    int cyc;
    int done_cyc;
    int n_fma;
    int n_wr;
    int n_done;
    logic busy_at_done;
    logic [5:0] raa_q [$];

    exp_series_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x_addr       (x_addr),
        .dst_addr     (dst_addr),
        .n_terms      (n_terms),
        .busy         (busy),
        .done         (done),
        .range_err    (range_err),
        .rf_enable    (rf_enable),
        .rf_raa       (rf_raa),
        .rf_rab       (rf_rab),
        .rf_wa        (rf_wa),
        .rf_data_in   (rf_data_in),
        .rf_data_outA (rf_data_outA),
        .rf_data_outB (rf_data_outB),
        .fma_start    (fma_start),
        .fma_a        (fma_a),
        .fma_b        (fma_b),
        .fma_c        (fma_c),
        .fma_done     (fma_done),
        .fma_result   (fma_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign rf_data_outA = rf_enable[0] ? mem[rf_raa] : 32'h0;
    assign rf_data_outB = rf_enable[1] ? mem[rf_rab] : 32'h0;
    assign fma_done     = fma_done_m | spur;
    assign fma_result   = spur ? 32'h4120_0000 : fma_result_m;

    function automatic real f2r(input logic [31:0] b);
        real m;
        real v;
        int  e;
        e = int'(b[30:23]);
        m = real'(b[22:0]) / 8388608.0;
        if (e == 0) v = m * (2.0 ** (-126));
        else        v = (1.0 + m) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real    a;
        int     e;
        longint mi;
        logic   s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mi = longint'((a - 1.0) * 8388608.0);
        if (mi >= 64'sd8388608) begin mi = 0; e++; end
        return {s, 8'(e + 127), 23'(mi)};
    endfunction

    function automatic logic [31:0] fma_f(input logic [31:0] a, b, c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    function automatic logic [31:0] horner(input logic [31:0] x, input int n);
        logic [31:0] acc;
        acc = coef[n];
        for (int k = n - 1; k >= 0; k--) acc = fma_f(acc, x, coef[k]);
        return acc;
    endfunction

    // Behavioural FMA: result valid 'lat' cycles after the start cycle
    initial begin
        int cnt;
        logic [31:0] ca, cb, cc;
        cnt = 0; ca = 0; cb = 0; cc = 0;
        fma_done_m = 1'b0;
        fma_result_m = 32'h0;
        forever begin
            @(negedge clk);
            fma_done_m = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fma_done_m   = 1'b1;
                    fma_result_m = fma_f(ca, cb, cc);
                    if (busy) begin
                        ntests++;
                        if ({fma_a, fma_b, fma_c} !== {ca, cb, cc}) begin
                            nfail++;
                            $display("FAIL fma_operands_stable: got %h %h %h, required %h %h %h",
                                     fma_a, fma_b, fma_c, ca, cb, cc);
                        end
                    end
                end
            end
            if (fma_start) begin
                cnt = lat; ca = fma_a; cb = fma_b; cc = fma_c;
            end
        end
    end

    // Bus monitor; also commits RF writes (no reads occur in WR)
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rf_enable == 3'b011) cyc = 1;
            else if (cyc > 0) cyc++;
            if (rf_enable[0]) raa_q.push_back(rf_raa);
            if (fma_start) n_fma++;
            if (rf_enable[2]) begin mem[rf_wa] = rf_data_in; n_wr++; end
            if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
        end
    end

    task automatic begin_op(input logic [5:0] xa, da, input logic [4:0] nt, input int l);
        lat = l; n_fma = 0; n_wr = 0; n_done = 0; done_cyc = 0; busy_at_done = 1'b1;
        raa_q.delete();
        @(negedge clk);
        x_addr = xa; dst_addr = da; n_terms = nt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_op();
        int t;
        t = 0;
        while (!done && t < 5000) begin @(negedge clk); t++; end
        ntests++;
        if (!done) begin
            nfail++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, t);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string nm, input logic [5:0] da, input logic [31:0] exp_v,
                            input int n, input int l);
        ntests++;
        if (mem[da] !== exp_v) begin
            nfail++;
            $display("FAIL %s_result: got %h, required %h", nm, mem[da], exp_v);
        end
        ntests++;
        if (done_cyc !== 3 + n * (l + 2)) begin
            nfail++;
            $display("FAIL %s_latency: got %0d, required %0d", nm, done_cyc, 3 + n * (l + 2));
        end
        ntests++;
        if (n_fma !== n || n_wr !== 1 || n_done !== 1 || busy_at_done !== 1'b0) begin
            nfail++;
            $display("FAIL %s_counts: fma=%0d wr=%0d done=%0d busy@done=%0b, required %0d 1 1 0",
                     nm, n_fma, n_wr, n_done, busy_at_done, n);
        end
    endtask

    task automatic check_idle(input string nm);
        ntests++;
        if ({busy, done, rf_enable, rf_raa, rf_rab, rf_wa, rf_data_in,
             fma_start, fma_a, fma_b, fma_c} !== '0) begin
            nfail++;
            $display("FAIL %s_outputs_zero: busy=%0b done=%0b en=%b raa=%0d rab=%0d wa=%0d din=%h fs=%0b a=%h b=%h c=%h, required all 0",
                     nm, busy, done, rf_enable, rf_raa, rf_rab, rf_wa, rf_data_in,
                     fma_start, fma_a, fma_b, fma_c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_idle("reset_asserted");
        ntests++;
        if (range_err !== 1'b0) begin
            nfail++;
            $display("FAIL reset_range_err: got %0b, required 0", range_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_zero_x();
        mem[40] = 32'h0000_0000;
        begin_op(6'd40, 6'd50, 5'd2, 3);
        wait_op();
        check_op("zero_x", 6'd50, 32'h3f80_0000, 2, 3);
        ntests++;
        if (range_err !== 1'b0) begin
            nfail++;
            $display("FAIL zero_x_range_err: got %0b, required 0", range_err);
        end
    endtask

    task automatic test_one_x();
        int d;
        logic [5:0] exp_q [$];
        exp_q = '{6'd3, 6'd2, 6'd1, 6'd0};
        mem[40] = 32'h3f80_0000;
        begin_op(6'd40, 6'd51, 5'd3, 3);
        wait_op();
        d = int'(mem[51]) - int'(32'h402a_aaab);
        ntests++;
        if (d > 1 || d < -1) begin
            nfail++;
            $display("FAIL one_x_result: got %h, required 402aaaab +-1 ulp", mem[51]);
        end
        ntests++;
        if (raa_q != exp_q) begin
            nfail++;
            $display("FAIL one_x_raa_seq: got %p, required %p", raa_q, exp_q);
        end
        check_op("one_x", 6'd51, horner(32'h3f80_0000, 3), 3, 3);
    endtask

    task automatic test_n_zero();
        mem[41] = r2f(1.5);
        mem[50] = 32'hdead_beef;
        begin_op(6'd41, 6'd50, 5'd0, 3);
        wait_op();
        check_op("n_zero", 6'd50, 32'h3f80_0000, 0, 3);
    endtask

    task automatic test_range();
        logic [31:0] xb;
        xb = r2f(0.75);
        mem[42] = xb;
        begin_op(6'd42, 6'd53, 5'd30, 2);
        wait_op();
        check_op("range", 6'd53, horner(xb, 25), 25, 2);
        ntests++;
        if (range_err !== 1'b1 || raa_q.size() == 0 || raa_q[0] !== 6'd25) begin
            nfail++;
            $display("FAIL range_flag_first_raa: err=%0b first_raa=%0d, required 1 25",
                     range_err, (raa_q.size() > 0) ? raa_q[0] : 6'd63);
        end
        begin_op(6'd42, 6'd54, 5'd2, 2);
        wait_op();
        check_op("range_clear", 6'd54, horner(xb, 2), 2, 2);
        ntests++;
        if (range_err !== 1'b0) begin
            nfail++;
            $display("FAIL range_clear_flag: got %0b, required 0", range_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xb;
        int t;
        xb = r2f(-1.25);
        mem[43] = xb;
        mem[44] = r2f(1.75);
        begin_op(6'd43, 6'd55, 5'd4, 3);
        @(negedge clk);
        x_addr = 6'd44; dst_addr = 6'd56; n_terms = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (rf_enable !== 3'b001 && t < 50) begin @(negedge clk); t++; end
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_op();
        check_op("back_to_back", 6'd55, horner(xb, 4), 4, 3);
        repeat (5) @(negedge clk);
        ntests++;
        if (busy !== 1'b0 || n_done !== 1 || n_wr !== 1) begin
            nfail++;
            $display("FAIL back_to_back_ignored: busy=%0b done=%0d wr=%0d, required 0 1 1",
                     busy, n_done, n_wr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int xi, n, l;
            logic [5:0] xa, da;
            logic [31:0] xb;
            xi = int'($urandom_range(4000)) - 2000;
            n  = int'($urandom_range(10, 1));
            l  = int'($urandom_range(5, 1));
            xa = 6'($urandom_range(45, 26));
            da = 6'($urandom_range(63, 26));
            xb = r2f(real'(xi) / 1000.0);
            mem[xa] = xb;
            begin_op(xa, da, 5'(n), l);
            wait_op();
            check_op("random", da, horner(xb, n), n, l);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        mem[40] = r2f(0.5);
        mem[52] = 32'h1234_5678;
        begin_op(6'd40, 6'd52, 5'd3, 6);
        t = 0;
        while (!fma_start && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle("reset_mid_asserted");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1 check_idle("reset_mid_after");
        ntests++;
        if (n_wr !== 0 || n_done !== 0 || mem[52] !== 32'h1234_5678) begin
            nfail++;
            $display("FAIL reset_mid_no_write: wr=%0d done=%0d mem=%h, required 0 0 12345678",
                     n_wr, n_done, mem[52]);
        end
    endtask

    initial begin
        real f;
        ntests = 0; nfail = 0; lat = 3; spur = 1'b0;
        n_fma = 0; n_wr = 0; n_done = 0; done_cyc = 0; busy_at_done = 1'b0;
        start = 1'b0; x_addr = '0; dst_addr = '0; n_terms = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        f = 1.0;
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) f = f * real'(k);
            coef[k] = r2f(1.0 / f);
            mem[k]  = coef[k];
        end
        test_reset();
        test_zero_x();
        test_one_x();
        test_n_zero();
        test_range();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule : tb_exp_series_seq
`default_nettype wire
